rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Writeback stage directly upstream of the CPU register file (A, X, Y, SP, P; byte registers behind one shared address port with a 16-bit data path).
- Accepts results from execute over a valid/ready handshake. Writes the destination register, then read-modify-writes the status register P: N/Z are computed from the result; C/V/I/D come from the request under a mask.
- Owns the register file's single address port and arbitrates it against decode-stage reads.

Parameters:
- P_B_KEEP, 1, when 1 the B flag (P[4]) is never modified by flag updates.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous reset, active-low
- wb_valid_i  in  1  execute result valid
- wb_ready_o  out  1  stage can accept a request
- wb_dst_en_i  in  1  destination register write requested
- wb_dst_i  in  reg_id_t  destination register
- wb_data_i  in  8  result byte
- wb_flag_mask_i  in  8  P bits to update (bit order N V 1 B D I Z C)
- wb_flag_val_i  in  8  new values for masked P bits; the N and Z positions are ignored
- wb_done_o  out  1  one-cycle pulse when a request retires
- rd_addr_i  in  reg_id_t  decode read address
- rd_data_o  out  8  decode read data
- rd_valid_o  out  1  rd_data_o is valid this cycle (port not in use by writeback)
- rf_addr_o  out  reg_id_t  register file address
- rf_we_o  out  1  register file write enable
- rf_wdata_o  out  16  register file write data; upper byte is always 0
- rf_rdata_i  in  16  register file read data; only the low byte is used

Behaviour:
- FSM states: IDLE, WR_DST, WR_P.
- Reset (asynchronous): state=IDLE, latched request cleared, rf_we_o=0, wb_done_o=0, wb_ready_o=1.
- Reset mid-transaction abandons the request; no partial write completes after reset deasserts.
- IDLE:
  - wb_ready_o=1.
  - Port mux: rf_addr_o=rd_addr_i, rd_valid_o=1, rd_data_o=rf_rdata_i[7:0], rf_we_o=0.
  - On wb_valid_i&wb_ready_o: latch dst_en, dst, data, mask, val. Next state:
    - WR_DST if dst_en.
    - else WR_P if mask!=0.
    - else IDLE, with wb_done_o pulsed in the next cycle.
- WR_DST:
  - Outputs: rf_addr_o=dst, rf_we_o=1, rf_wdata_o={8'h00,data}, wb_ready_o=0, rd_valid_o=0.
  - Next state is WR_P if mask!=0 and dst!=REG_P; otherwise IDLE, pulsing wb_done_o.
  - dst==REG_P (PLP/TXS-style): the flag update is skipped; the explicit write wins.
- WR_P (single cycle, uses combinational read then write at the edge):
  - rf_addr_o=REG_P, rf_we_o=1, wb_ready_o=0, rd_valid_o=0.
  - Computed flags: N=data[7]; Z=(data==0). N/Z come from latched data even when dst_en=0 (CMP/BIT-style).
  - eff_val = val with bits 7/1 replaced by the computed N/Z.
  - eff_mask = mask with bit 5 cleared; bit 4 also cleared if P_B_KEEP.
  - new_p = (rf_rdata_i[7:0] & ~eff_mask) | (eff_val & eff_mask) | 8'h20 (bit 5 forced to 1).
  - rf_wdata_o={8'h00,new_p}. Next state IDLE; wb_done_o pulses in the following cycle.
- Latency from accept edge:
  - dst write commits at end of cycle +1.
  - P write commits at end of cycle +1 (no dst) or +2.
  - wb_done_o is high in the cycle after the last write.
- Throughput: no back-to-back acceptance. wb_ready_o is low in every non-IDLE cycle, so a new request is accepted in the cycle the FSM returns to IDLE.
- Decode reads during a busy cycle get rd_valid_o=0; decode must stall. rd_data_o then mirrors internal reads and is don't-care.
- wb_valid_i while not ready: the request must be held stable by the sender; no state change here.

Decomposition:
- Shared package cpu_pkg:
  - reg_id_t enum: REG_A=0, REG_X=1, REG_Y=2, REG_SP=3, REG_P=4.
  - `BYTE.
  - P bit-index constants: FLAG_N=7, FLAG_V=6, FLAG_U=5, FLAG_B=4, FLAG_D=3, FLAG_I=2, FLAG_Z=1, FLAG_C=0.
  - wb_state_t.
- One natural sub-module, flag_merge: purely combinational new_p computation. It is reused later by the interrupt/PHP logic.

Test Plan:
- Reset with P=8'h24: request dst_en=1, dst=REG_A, data=8'h00, mask=8'h82 -> A=0x00 at cycle+1; P=0x26 at cycle+2; wb_done_o pulses at cycle+3.
- dst_en=0 (CMP), data=8'h80, mask=8'h83, val=8'h01, P=0x24 -> no dst write; P=0xA5 at cycle+1; single done pulse.
- dst=REG_P, data=8'hFF, mask=8'hFF -> P written 0xFF once; no WR_P cycle; done at cycle+2.
- Decode reads rd_addr_i=REG_X during WR_DST -> rd_valid_o=0. Read of X in the IDLE cycle after done -> rd_valid_o=1 with the correct value.
- mask=0, dst_en=0 -> no rf_we_o; done pulse in the next cycle; wb_ready_o stays 1.
- rstn_i asserted in WR_DST -> rf_we_o drops immediately; P unchanged; after release state=IDLE and wb_ready_o=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register ids, P flag bit positions and writeback
// FSM state/request types.
package cpu_pkg;

    localparam int unsigned BYTE     = 8;
    localparam int unsigned WORD     = 16;
    localparam int unsigned REG_ID_W = 3;

    typedef enum logic [REG_ID_W-1:0] {
        REG_A  = 3'd0,
        REG_X  = 3'd1,
        REG_Y  = 3'd2,
        REG_SP = 3'd3,
        REG_P  = 3'd4
    } reg_id_t;

    localparam int unsigned FLAG_N = 7;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_U = 5;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_DST = 2'd1,
        WR_P   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic            dst_en;
        reg_id_t         dst;
        logic [BYTE-1:0] data;
        logic [BYTE-1:0] mask;
        logic [BYTE-1:0] val;
    } wb_req_t;

endpackage

// File: rtl/flag_merge.sv
// Merges a result's N/Z and requested C/V/I/D bits into the status register.
// Purely combinational; also used by the interrupt/PHP path.
module flag_merge
    import cpu_pkg::*;
#(
    parameter bit P_B_KEEP = 1'b1
) (
    input  logic [BYTE-1:0] i_p_old,
    input  logic [BYTE-1:0] i_data,
    input  logic [BYTE-1:0] i_mask,
    input  logic [BYTE-1:0] i_val,
    output logic [BYTE-1:0] o_p_new
);

    logic [BYTE-1:0] w_eff_val;
    logic [BYTE-1:0] w_eff_mask;

    // N/Z always derive from the result byte; bit 5 reads as 1 and is never masked in
    always_comb begin
        w_eff_val          = i_val;
        w_eff_val[FLAG_N]  = i_data[BYTE-1];
        w_eff_val[FLAG_Z]  = (i_data == '0);
        w_eff_mask         = i_mask;
        w_eff_mask[FLAG_U] = 1'b0;
        if (P_B_KEEP) begin
            w_eff_mask[FLAG_B] = 1'b0;
        end
        o_p_new         = (i_p_old & ~w_eff_mask) | (w_eff_val & w_eff_mask);
        o_p_new[FLAG_U] = 1'b1;
    end

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: writes the destination register, then read-modify-writes P,
// while sharing the register file address port with decode reads.
module rf_writeback
    import cpu_pkg::*;
#(
    parameter bit P_B_KEEP = 1'b1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic            wb_dst_en_i,
    input  reg_id_t         wb_dst_i,
    input  logic [BYTE-1:0] wb_data_i,
    input  logic [BYTE-1:0] wb_flag_mask_i,
    input  logic [BYTE-1:0] wb_flag_val_i,
    output logic            wb_done_o,
    input  reg_id_t         rd_addr_i,
    output logic [BYTE-1:0] rd_data_o,
    output logic            rd_valid_o,
    output reg_id_t         rf_addr_o,
    output logic            rf_we_o,
    output logic [WORD-1:0] rf_wdata_o,
    input  logic [WORD-1:0] rf_rdata_i
);

    wb_state_t       r_state;
    wb_state_t       w_state_nxt;
    wb_req_t         r_req;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_accept;
    logic [BYTE-1:0] w_p_new;
    logic            w_unused;

    assign w_accept   = wb_valid_i & wb_ready_o;
    assign wb_done_o  = r_done;
    assign rd_data_o  = rf_rdata_i[BYTE-1:0];
    assign w_unused   = ^rf_rdata_i[WORD-1:BYTE];

    flag_merge #(
        .P_B_KEEP (P_B_KEEP)
    ) u_flag_merge (
        .i_p_old  (rf_rdata_i[BYTE-1:0]),
        .i_data   (r_req.data),
        .i_mask   (r_req.mask),
        .i_val    (r_req.val),
        .o_p_new  (w_p_new)
    );

    // State, latched request and retire pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_req.dst_en <= wb_dst_en_i;
                r_req.dst    <= wb_dst_i;
                r_req.data   <= wb_data_i;
                r_req.mask   <= wb_flag_mask_i;
                r_req.val    <= wb_flag_val_i;
            end
        end
    end

    // Next state and register file port mux
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        wb_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        rf_addr_o   = rd_addr_i;
        rf_we_o     = 1'b0;
        rf_wdata_o  = '0;
        case (r_state)
            IDLE: begin
                wb_ready_o = 1'b1;
                rd_valid_o = 1'b1;
                if (wb_valid_i) begin
                    if (wb_dst_en_i) begin
                        w_state_nxt = WR_DST;
                    end else if (wb_flag_mask_i != '0) begin
                        w_state_nxt = WR_P;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            WR_DST: begin
                rf_addr_o  = r_req.dst;
                rf_we_o    = 1'b1;
                rf_wdata_o = WORD'(r_req.data);
                // An explicit write to P supersedes the flag update
                if (r_req.mask != '0 && r_req.dst != REG_P) begin
                    w_state_nxt = WR_P;
                end else begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            WR_P: begin
                rf_addr_o   = REG_P;
                rf_we_o     = 1'b1;
                rf_wdata_o  = WORD'(w_p_new);
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized bench for rf_writeback against a transaction-level model of the
// register file contents, write counts and retire latency.
module tb_rf_writeback;
    import cpu_pkg::*;

    localparam bit B_KEEP = 1'b1;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic        wb_dst_en_i;
    reg_id_t     wb_dst_i;
    logic [7:0]  wb_data_i;
    logic [7:0]  wb_flag_mask_i;
    logic [7:0]  wb_flag_val_i;
    logic        wb_done_o;
    reg_id_t     rd_addr_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    reg_id_t     rf_addr_o;
    logic        rf_we_o;
    logic [15:0] rf_wdata_o;
    logic [15:0] rf_rdata_i;

    logic [15:0] rf_mem [5];
    logic        tb_load;
    int          tb_load_idx;
    logic [15:0] tb_load_val;

    logic [7:0]  m_reg [5];
    reg_id_t     rd_pick;
    int          n_vec;
    int          n_err;

    always #5 clk_i = ~clk_i;

    rf_writeback #(
        .P_B_KEEP (B_KEEP)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .wb_valid_i     (wb_valid_i),
        .wb_ready_o     (wb_ready_o),
        .wb_dst_en_i    (wb_dst_en_i),
        .wb_dst_i       (wb_dst_i),
        .wb_data_i      (wb_data_i),
        .wb_flag_mask_i (wb_flag_mask_i),
        .wb_flag_val_i  (wb_flag_val_i),
        .wb_done_o      (wb_done_o),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .rf_addr_o      (rf_addr_o),
        .rf_we_o        (rf_we_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_rdata_i     (rf_rdata_i)
    );

    // Register file: combinational read, write at the clock edge
    always_comb begin
        rf_rdata_i = 16'h0000;
        if (int'(rf_addr_o) < 5) rf_rdata_i = rf_mem[int'(rf_addr_o)];
    end

    always @(posedge clk_i) begin
        if (tb_load) rf_mem[tb_load_idx] <= tb_load_val;
        else if (rf_we_o && int'(rf_addr_o) < 5) rf_mem[int'(rf_addr_o)] <= rf_wdata_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flag rules applied bit by bit
    function automatic logic [7:0] ref_p(input logic [7:0] old, input logic [7:0] data,
                                         input logic [7:0] mask, input logic [7:0] val);
        logic [7:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) r[i] = 1'b1;
            else if (i == 4 && B_KEEP) r[i] = old[i];
            else if (mask[i]) begin
                if (i == 7) r[i] = data[7];
                else if (i == 1) r[i] = (data == 8'h00);
                else r[i] = val[i];
            end
        end
        return r;
    endfunction

    task automatic load_reg(input int idx, input logic [7:0] v);
        @(negedge clk_i);
        tb_load = 1'b1; tb_load_idx = idx; tb_load_val = {8'h00, v};
        @(negedge clk_i);
        tb_load = 1'b0;
        m_reg[idx] = v;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++) check_eq(tag, {16'h0, rf_mem[i]}, {24'h0, m_reg[i]});
    endtask

    task automatic run_req(input logic en, input logic [2:0] dst, input logic [7:0] data,
                           input logic [7:0] mask, input logic [7:0] val);
        bit p_upd, done_seen;
        int writes, cyc, we_cnt;
        p_upd  = (mask != 8'h00) && !(en && dst == 3'd4);
        writes = (en ? 1 : 0) + (p_upd ? 1 : 0);
        @(negedge clk_i);
        rd_addr_i = rd_pick;
        #1;
        check_eq("ready_idle", 32'(wb_ready_o), 32'd1);
        check_eq("done_idle", 32'(wb_done_o), 32'd0);
        check_eq("rd_valid_idle", 32'(rd_valid_o), 32'd1);
        check_eq("rd_data_idle", 32'(rd_data_o), 32'(m_reg[int'(rd_pick)]));
        wb_valid_i = 1'b1; wb_dst_en_i = en; wb_dst_i = reg_id_t'(dst);
        wb_data_i = data; wb_flag_mask_i = mask; wb_flag_val_i = val;
        @(posedge clk_i);
        #1;
        wb_valid_i = 1'b0;
        if (en) m_reg[dst] = data;
        if (p_upd) m_reg[4] = ref_p(m_reg[4], data, mask, val);
        cyc = 0; we_cnt = 0; done_seen = 0;
        while (!done_seen && cyc < 8) begin
            @(negedge clk_i);
            cyc++;
            if (rf_we_o) we_cnt++;
            if (wb_done_o) done_seen = 1;
            else begin
                check_eq("ready_busy", 32'(wb_ready_o), 32'd0);
                check_eq("rd_valid_busy", 32'(rd_valid_o), 32'd0);
            end
        end
        check_eq("done_seen", 32'(done_seen), 32'd1);
        check_eq("latency", 32'(cyc), 32'(writes + 1));
        check_eq("we_cycles", 32'(we_cnt), 32'(writes));
        check_eq("ready_at_done", 32'(wb_ready_o), 32'd1);
        check_eq("rd_valid_at_done", 32'(rd_valid_o), 32'd1);
        check_eq("rd_data_at_done", 32'(rd_data_o), 32'(m_reg[int'(rd_pick)]));
        check_regs("regs_after_req");
        @(negedge clk_i);
        check_eq("done_one_cycle", 32'(wb_done_o), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rstn_i = 1'b0; wb_valid_i = 1'b0; wb_dst_en_i = 1'b0; wb_dst_i = REG_A;
        wb_data_i = 8'h00; wb_flag_mask_i = 8'h00; wb_flag_val_i = 8'h00;
        rd_addr_i = REG_A; rd_pick = REG_A; tb_load = 1'b0; tb_load_idx = 0; tb_load_val = 16'h0;
        load_reg(0, 8'h11); load_reg(1, 8'h22); load_reg(2, 8'h33);
        load_reg(3, 8'hFD); load_reg(4, 8'h24);
        #1;
        check_eq("rst_ready", 32'(wb_ready_o), 32'd1);
        check_eq("rst_done", 32'(wb_done_o), 32'd0);
        check_eq("rst_we", 32'(rf_we_o), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Load A then N/Z update
        load_reg(4, 8'h24);
        run_req(1'b1, 3'd0, 8'h00, 8'h82, 8'h00);
        check_eq("plan_lda_a", 32'(rf_mem[0]), 32'h0000);
        check_eq("plan_lda_p", 32'(rf_mem[4]), 32'h0026);

        // Compare-style: flags only
        load_reg(4, 8'h24);
        rd_pick = REG_X;
        run_req(1'b0, 3'd0, 8'h80, 8'h83, 8'h01);
        check_eq("plan_cmp_p", 32'(rf_mem[4]), 32'h00A5);

        // Direct P write wins over flag update
        run_req(1'b1, 3'd4, 8'hFF, 8'hFF, 8'h00);
        check_eq("plan_plp_p", 32'(rf_mem[4]), 32'h00FF);

        // No-op request
        run_req(1'b0, 3'd1, 8'h5A, 8'h00, 8'hFF);

        // Reset while in WR_DST
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_dst_en_i = 1'b1; wb_dst_i = REG_A;
        wb_data_i = 8'h5A; wb_flag_mask_i = 8'h83; wb_flag_val_i = 8'h00;
        @(posedge clk_i);
        #1;
        wb_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_mid_we_before", 32'(rf_we_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check_eq("rst_mid_we", 32'(rf_we_o), 32'd0);
        check_eq("rst_mid_ready", 32'(wb_ready_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("rst_mid_ready_after", 32'(wb_ready_o), 32'd1);
        check_eq("rst_mid_done", 32'(wb_done_o), 32'd0);
        check_regs("regs_after_rst");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [7:0] msk;
            rd_pick = reg_id_t'(3'($urandom_range(0, 4)));
            msk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_req(1'($urandom), 3'($urandom_range(0, 4)), 8'($urandom), msk, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
